// File: rtl/text_console_buffer.sv
`default_nettype none
// ============================================================================
// Module : text_console_buffer
// Purpose: Character-cell screen buffer and terminal controller. Accepts
//          ASCII bytes over a valid/ready handshake, maintains cursor, line
//          wrap, backspace, form-feed clear and hardware scroll, and serves
//          packed 4-character words to the VGA stage.
// Ports  : CLOCK_50      system clock (rising edge)
//          rst_n         synchronous active-low reset
//          in_valid/in_char/in_ready   character input handshake
//          font_address  VGA read address {row[4:0], col[6:0]}, col[1:0] ignored
//          char          registered packed word, col%4=0 in [31:24]
//          cursor_row/cursor_col       logical cursor position
//          busy          clear or scroll in progress
// Option : define CURSOR_BLINK_EN to overlay a blinking '_' at the cursor
//          on the read port (period set by BLINK_DIV).
// Rev    : 1.0  initial release
// ============================================================================
module text_console_buffer #(
  parameter int ROWS      = 30,
  parameter int COLS      = 40,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic [11:0] font_address,
  output logic [31:0] char,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam int          WORDS  = ROWS * COLS / 4;
  localparam int          WPR    = COLS / 4;
  localparam int          AW     = $clog2(WORDS);
  localparam logic [31:0] SPACES = 32'h2020_2020;

  if (((COLS % 4) != 0) || (BLINK_DIV < 1)) begin : g_param_check
    $error("text_console_buffer: COLS must be a multiple of 4 and BLINK_DIV >= 1");
  end

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    top_q, top_d;
  logic [4:0]    row_q, row_d;
  logic [6:0]    col_q, col_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [4:0]    freed_q, freed_d;   // physical row released by the last scroll
  logic [31:0]   char_q, char_d;

  logic [31:0]   mem_q [0:WORDS-1];

  logic [3:0]    we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          adv;
  logic [4:0]    wr_row;
  logic [6:0]    wr_col;

  // Logical row plus scroll pointer, wrapped into the physical row range.
  function automatic logic [AW-1:0] word_addr(input logic [4:0] lrow,
                                              input logic [4:0] top,
                                              input logic [4:0] cword);
    logic [5:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return AW'(32'(sum) * WPR + 32'(cword));
  endfunction

  // --------------------------------------------------------------------------
  // Next-state, cursor and write-port control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    freed_d  = freed_q;
    we       = 4'h0;
    waddr    = '0;
    wdata    = SPACES;
    adv      = 1'b0;
    wr_row   = row_q;
    wr_col   = col_q;
    in_ready = 1'b0;
    busy     = 1'b1;

    unique case (state_q)
      CLR_ALL: begin
        we    = 4'hF;
        waddr = cnt_q;
        if (cnt_q == AW'(WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      CLR_ROW: begin
        we    = 4'hF;
        waddr = word_addr(freed_q, 5'd0, cnt_q[4:0]);
        if (cnt_q == AW'(WPR - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      IDLE: begin
        busy     = 1'b0;
        // A byte offered while reset is asserted must not be taken.
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          if ((in_char >= 8'h20) && (in_char <= 8'h7E)) begin
            we    = 4'b1000 >> col_q[1:0];
            wdata = {4{in_char}};
            if (col_q == 7'(COLS - 1)) begin
              col_d = 7'd0;
              adv   = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (in_char)
              8'h0A: begin
                col_d = 7'd0;
                adv   = 1'b1;
              end
              8'h0D: col_d = 7'd0;
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d  = col_q - 7'd1;
                  wr_col = col_q - 7'd1;
                  we     = 4'b1000 >> wr_col[1:0];
                end else if (row_q != 5'd0) begin
                  row_d  = row_q - 5'd1;
                  col_d  = 7'(COLS - 1);
                  wr_row = row_q - 5'd1;
                  wr_col = 7'(COLS - 1);
                  we     = 4'b1000 >> wr_col[1:0];
                end
              end
              8'h0C: begin
                top_d   = 5'd0;
                row_d   = 5'd0;
                col_d   = 7'd0;
                cnt_d   = '0;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
          waddr = word_addr(wr_row, top_q, wr_col[6:2]);
        end
      end

      default: state_d = CLR_ALL;
    endcase

    // Row advance: on the last row the screen scrolls and the old top
    // physical row becomes the new bottom row, which is then blanked.
    if (adv) begin
      if (row_q != 5'(ROWS - 1)) begin
        row_d = row_q + 5'd1;
      end else begin
        top_d   = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 5'd1;
        freed_d = top_q;
        cnt_d   = '0;
        state_d = CLR_ROW;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      top_q   <= 5'd0;
      row_q   <= 5'd0;
      col_q   <= 7'd0;
      cnt_q   <= '0;
      freed_q <= 5'd0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      freed_q <= freed_d;
    end
  end

  // Byte-lane write port; storage itself is not reset, CLR_ALL blanks it.
  always_ff @(posedge CLOCK_50) begin
    if (rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // VGA read port (logical row, mapped through the scroll pointer)
  // --------------------------------------------------------------------------
  logic [4:0]    rd_row;
  logic [4:0]    rd_word;
  logic          rd_ok;
  logic [AW-1:0] raddr;
  logic          unused_addr_lsbs;

  assign rd_row           = font_address[11:7];
  assign rd_word          = font_address[6:2];
  assign unused_addr_lsbs = ^font_address[1:0];
  assign rd_ok            = (rd_row < 5'(ROWS)) && (rd_word < 5'(WPR));
  assign raddr            = word_addr(rd_row, top_q, rd_word);

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_hide_q;   // 0 = cursor visible

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      blink_cnt_q  <= '0;
      blink_hide_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q  <= '0;
      blink_hide_q <= ~blink_hide_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end
`endif

  always_comb begin
    char_d = rd_ok ? mem_q[raddr] : 32'h0;
`ifdef CURSOR_BLINK_EN
    // Overlay only on the output path; stored text is untouched.
    if (!blink_hide_q && rd_ok && (rd_row == row_q) && (rd_word == col_q[6:2])) begin
      case (col_q[1:0])
        2'd0:    char_d[31:24] = 8'h5F;
        2'd1:    char_d[23:16] = 8'h5F;
        2'd2:    char_d[15:8]  = 8'h5F;
        default: char_d[7:0]   = 8'h5F;
      endcase
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) char_q <= 32'h0;
    else        char_q <= char_d;
  end

  assign char       = char_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
`default_nettype wire

// File: tb/tb_text_console_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_text_console_buffer
// Purpose: Directed self-checking bench for text_console_buffer: reset clear,
//          packing, wrap/backspace, scroll, reset during scroll, cursor blink
//          overlay (or its absence) and form-feed clear.
// Rev    : 1.0  initial release
// ============================================================================
module tb_text_console_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic [11:0] font_address;
  logic [31:0] char_w;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  text_console_buffer #(
    .ROWS(30),
    .COLS(40),
    .BLINK_DIV(4)
  ) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_char     (in_char),
    .in_ready    (in_ready),
    .font_address(font_address),
    .char        (char_w),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_char  = b;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] r, input logic [6:0] c, output logic [31:0] d);
    font_address = {r, c};
    tick();
    d = char_w;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          bad;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_char      = 8'h00;
    font_address = 12'h000;

    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_char",  char_w, 32'h0);
    chk("rst_row",   32'(cursor_row), 32'd0);
    chk("rst_col",   32'(cursor_col), 32'd0);
    rst_n = 1'b1;
    count_busy(n);
    chk("clr_all_cycles", 32'(n), 32'd300);
    chk("clr_all_ready",  32'(in_ready), 32'd1);
    rd(5'd0,  7'd0,  d); chk("clr_r0w0",  d, 32'h20202020);
    rd(5'd29, 7'd36, d); chk("clr_r29w9", d, 32'h20202020);
    rd(5'd15, 7'd20, d); chk("clr_r15w5", d, 32'h20202020);

    // ---------------- pack ----------------
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_char  = 8'h41 + 8'(i);
      chk("pack_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    rd(5'd0, 7'd0, d);
    chk("pack_word", d, 32'h41424344);
    chk("pack_col",  32'(cursor_col), 32'd4);

    // ---------------- wrap / backspace ----------------
    send(8'h0D);
    chk("cr_col", 32'(cursor_col), 32'd0);
    for (int i = 0; i < 39; i++) send(8'h78);
    chk("x39_col", 32'(cursor_col), 32'd39);
    send(8'h78);
    chk("wrap_row", 32'(cursor_row), 32'd1);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    send(8'h08);
    chk("bs_row", 32'(cursor_row), 32'd0);
    chk("bs_col", 32'(cursor_col), 32'd39);
    rd(5'd0, 7'd36, d); chk("bs_word9", d, 32'h78787820);
    rd(5'd0, 7'd0,  d); chk("x_word0",  d, 32'h78787878);
    send(8'h07);
    send(8'h7F);
    chk("ignored_row", 32'(cursor_row), 32'd0);
    chk("ignored_col", 32'(cursor_col), 32'd39);
    rd(5'd0, 7'd36, d); chk("ignored_word9", d, 32'h78787820);

    // ---------------- scroll ----------------
    send(8'h0A);
    chk("nl_row", 32'(cursor_row), 32'd1);
    for (int r = 1; r < 30; r++) begin
      send(8'h40 + 8'(r));
      if (r < 29) send(8'h0A);
    end
    chk("fill_row", 32'(cursor_row), 32'd29);
    chk("fill_col", 32'(cursor_col), 32'd1);
    in_valid = 1'b1;
    in_char  = 8'h0A;
    chk("scroll_ready_before", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n   = 0;
    bad = 0;
    while (busy && n < 100) begin
      if (in_ready) bad++;
      n++;
      tick();
    end
    chk("scroll_busy_cycles", 32'(n), 32'd10);
    chk("scroll_ready_low",   32'(bad), 32'd0);
    chk("scroll_row", 32'(cursor_row), 32'd29);
    chk("scroll_col", 32'(cursor_col), 32'd0);
    rd(5'd0,  7'd0,  d); chk("scroll_r0",   d, 32'h41202020);
    rd(5'd28, 7'd0,  d); chk("scroll_r28",  d, 32'h5D202020);
    rd(5'd29, 7'd0,  d); chk("scroll_r29a", d, 32'h20202020);
    rd(5'd29, 7'd36, d); chk("scroll_r29b", d, 32'h20202020);

    // ---------------- reset during CLR_ROW ----------------
    send(8'h0A);
    chk("scroll2_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_char  = 8'h5A;
    chk("rst_gates_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_row",  32'(cursor_row), 32'd0);
    chk("midrst_col",  32'(cursor_col), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst_n   = 1'b1;
    in_char = 8'h51;
    n = 0;
    while (!in_ready && n < 1000) begin
      n++;
      tick();
    end
    chk("midrst_stall", 32'(n), 32'd300);
    chk("midrst_noaccept", 32'(cursor_col), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("midrst_accept_col", 32'(cursor_col), 32'd1);
    rd(5'd0,  7'd0,  d); chk("midrst_r0",   d, 32'h51202020);
    rd(5'd29, 7'd36, d); chk("midrst_r29",  d, 32'h20202020);

    // ---------------- cursor blink overlay at 0,1 ----------------
    font_address = 12'h000;
    tick();
`ifdef CURSOR_BLINK_EN
    n   = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (char_w[23:16] == 8'h5F) n++;
      else if (char_w[23:16] == 8'h20) bad++;
      chk("blink_other_lanes", {8'h00, char_w[31:24], char_w[15:0]}, 32'h00512020);
    end
    chk("blink_visible", 32'(n), 32'd8);
    chk("blink_hidden",  32'(bad), 32'd8);
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("noblink_word", char_w, 32'h51202020);
    end
`endif

    // ---------------- form feed ----------------
    send(8'h0C);
    chk("ff_row", 32'(cursor_row), 32'd0);
    chk("ff_col", 32'(cursor_col), 32'd0);
    count_busy(n);
    chk("ff_clear_cycles", 32'(n), 32'd300);
    font_address = 12'h010;
    tick();
    rd(5'd0,  7'd0, d); chk("ff_r0",  d, 32'h20202020);
    rd(5'd28, 7'd0, d); chk("ff_r28", d, 32'h20202020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
